// File: rtl/sample_stats_pkg.sv
// rtl/sample_stats_pkg.sv - shared types and constants for the sample statistics collector
package sample_stats_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

    localparam int RPT_PASS = 0;
    localparam int RPT_FAIL = 1;
    localparam int RPT_BIN0 = 2;

    function automatic int bin_width(input int num_bins);
        return (num_bins > 1) ? $clog2(num_bins) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating tally counter with a saturation-hit pulse
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         sat_hit
);

    logic at_max;

    assign at_max  = (value == {W{1'b1}});
    assign sat_hit = inc && at_max && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && !at_max) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/sample_stats.sv
// rtl/sample_stats.sv - run statistics collector: pass/fail/histogram tallies with streamed report
module sample_stats
    import sample_stats_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NUM_BINS    = 4,
    parameter int CNT_W       = 4,
    parameter int NUM_SAMPLES = 13
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          rpt_valid,
    input  logic                          rpt_ready,
    output logic [CNT_W-1:0]              rpt_data,
    output logic [$clog2(NUM_BINS+2)-1:0] rpt_idx,
    output logic                          rpt_last,
    output logic                          busy,
    output logic                          ovf
);

    localparam int BIN_W  = bin_width(NUM_BINS);
    localparam int IDX_W  = $clog2(NUM_BINS + 2);
    localparam int SCNT_W = $clog2(NUM_SAMPLES + 1);
    localparam int NUM_T  = NUM_BINS + 2;

    state_t            state;
    logic [SCNT_W-1:0] sample_cnt;
    logic              accept;
    logic              clr;
    logic              last_sample;
    logic [NUM_T-1:0]  inc;
    logic [NUM_T-1:0]  hit;
    logic [CNT_W-1:0]  tally [NUM_T];
    logic [IDX_W-1:0]  next_idx;
    logic [CNT_W-1:0]  pass_next;
    logic              data_unused;

    assign accept      = (state == COLLECT) && in_valid && in_ready;
    assign clr         = (state == IDLE) && start;
    assign last_sample = accept && (sample_cnt == SCNT_W'(NUM_SAMPLES - 1));
    assign next_idx    = rpt_idx + IDX_W'(1);
    assign data_unused = ^in_data;

    assign inc[RPT_PASS] = accept && in_data[0];
    assign inc[RPT_FAIL] = accept && !in_data[0];

    for (genvar b = 0; b < NUM_BINS; b++) begin : g_bin_inc
        assign inc[RPT_BIN0+b] = accept && (in_data[DATA_W-1 -: BIN_W] == BIN_W'(b));
    end

    for (genvar t = 0; t < NUM_T; t++) begin : g_tally
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr),
            .inc     (inc[t]),
            .value   (tally[t]),
            .sat_hit (hit[t])
        );
    end

    // The run can end on the same edge that bumps the pass tally, so the first
    // report word is loaded from the counter's next value rather than its current one.
    assign pass_next = (inc[RPT_PASS] && (tally[RPT_PASS] != {CNT_W{1'b1}}))
                     ? tally[RPT_PASS] + CNT_W'(1) : tally[RPT_PASS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            ovf        <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            rpt_valid  <= 1'b0;
            rpt_data   <= '0;
            rpt_idx    <= '0;
            rpt_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= COLLECT;
                        sample_cnt <= '0;
                        ovf        <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        sample_cnt <= sample_cnt + SCNT_W'(1);
                    end
                    ovf <= ovf | (|hit);
                    if (last_sample || flush) begin
                        state     <= REPORT;
                        in_ready  <= 1'b0;
                        rpt_valid <= 1'b1;
                        rpt_idx   <= '0;
                        rpt_data  <= pass_next;
                        rpt_last  <= 1'b0;
                    end
                end
                REPORT: begin
                    if (rpt_ready) begin
                        if (rpt_last) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            rpt_valid <= 1'b0;
                            rpt_idx   <= '0;
                            rpt_data  <= '0;
                            rpt_last  <= 1'b0;
                        end else begin
                            rpt_idx  <= next_idx;
                            rpt_data <= tally[next_idx];
                            rpt_last <= (next_idx == IDX_W'(NUM_BINS + 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_stats.sv
// tb/tb_sample_stats.sv - scoreboard bench for sample_stats (default and NUM_SAMPLES=20 instances)
module tb_sample_stats;

    logic       clk = 1'b0;
    logic       rst, start, start2, flush, in_valid, rpt_ready;
    logic [7:0] in_data;

    logic       in_ready1, rpt_valid1, rpt_last1, busy1, ovf1;
    logic [3:0] rpt_data1;
    logic [2:0] rpt_idx1;
    logic       in_ready2, rpt_valid2, rpt_last2, busy2, ovf2;
    logic [3:0] rpt_data2;
    logic [2:0] rpt_idx2;

    sample_stats dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .rpt_valid(rpt_valid1), .rpt_ready(rpt_ready), .rpt_data(rpt_data1),
        .rpt_idx(rpt_idx1), .rpt_last(rpt_last1), .busy(busy1), .ovf(ovf1)
    );

    sample_stats #(.NUM_SAMPLES(20)) dut20 (
        .clk(clk), .rst(rst), .start(start2), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .rpt_valid(rpt_valid2), .rpt_ready(rpt_ready), .rpt_data(rpt_data2),
        .rpt_idx(rpt_idx2), .rpt_last(rpt_last2), .busy(busy2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    bit sel = 1'b0;
    wire       cur_in_ready  = sel ? in_ready2  : in_ready1;
    wire       cur_rpt_valid = sel ? rpt_valid2 : rpt_valid1;
    wire       cur_rpt_last  = sel ? rpt_last2  : rpt_last1;
    wire       cur_busy      = sel ? busy2      : busy1;
    wire       cur_ovf       = sel ? ovf2       : ovf1;
    wire [3:0] cur_rpt_data  = sel ? rpt_data2  : rpt_data1;
    wire [2:0] cur_rpt_idx   = sel ? rpt_idx2   : rpt_idx1;

    typedef struct {int idx; int data; int last;} word_t;
    word_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int m_cnt[6];
    int m_ovf;
    int hs;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 6; i++) m_cnt[i] = 0;
        m_ovf = 0;
    endfunction

    function automatic void model_bump(input int t);
        if (m_cnt[t] == 15) m_ovf = 1;
        else m_cnt[t]++;
    endfunction

    function automatic void model_add(input int d);
        model_bump((d & 1) ? 0 : 1);
        model_bump(2 + ((d >> 6) & 3));
    endfunction

    function automatic void push_report();
        for (int i = 0; i < 6; i++) exp_q.push_back('{i, m_cnt[i], (i == 5) ? 1 : 0});
    endfunction

    task automatic do_start();
        if (sel) start2 = 1'b1;
        else start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start2 = 1'b0;
        model_clear();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic send(input int d, input bit fl);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d[7:0];
        flush    = fl;
        while (!cur_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("send_ready", int'(cur_in_ready), 1);
        if (cur_in_ready) model_add(d);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic drain(input int stall_idx, input int stall_n, input int stop_idx, output int nhs);
        int n = 0;
        int stalls = stall_n;
        word_t w;
        nhs = 0;
        while (exp_q.size() > 0 && n < 100) begin
            if (cur_rpt_valid) begin
                w = exp_q[0];
                if (w.idx == stop_idx) begin
                    rpt_ready = 1'b0;
                    return;
                end
                rpt_ready = !(w.idx == stall_idx && stalls > 0);
                if (!rpt_ready) stalls--;
                check_eq("rpt_idx", int'(cur_rpt_idx), w.idx);
                check_eq("rpt_data", int'(cur_rpt_data), w.data);
                check_eq("rpt_last", int'(cur_rpt_last), w.last);
                check_eq("in_ready_in_report", int'(cur_in_ready), 0);
                if (rpt_ready) begin
                    void'(exp_q.pop_front());
                    nhs++;
                end
            end else begin
                rpt_ready = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        rpt_ready = 1'b1;
        check_eq("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_valid"}, int'(cur_rpt_valid), 0);
        check_eq({tag, "_idx"}, int'(cur_rpt_idx), 0);
        check_eq({tag, "_last"}, int'(cur_rpt_last), 0);
        check_eq({tag, "_busy"}, int'(cur_busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; rpt_ready = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", int'(in_ready1), 0);
        check_eq("rst_rpt_data", int'(rpt_data1), 0);
        check_eq("rst_ovf", int'(ovf1), 0);
        check_idle("rst");
        rst = 1'b0;
        @(negedge clk);

        // 0..12 back to back, with a stray start mid-run
        do_start();
        check_eq("t1_busy", int'(busy1), 1);
        check_eq("t1_in_ready", int'(in_ready1), 1);
        for (int d = 0; d < 13; d++) begin
            send(d, 1'b0);
            if (d == 2) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check_eq("t1_start_ignored", int'(busy1), 1);
            end
        end
        push_report();
        drain(-1, 0, -1, hs);
        check_eq("t1_handshakes", hs, 6);
        check_eq("t1_ovf", int'(ovf1), 0);
        check_idle("t1_end");

        // one sample per bin, flush, backpressure on idx 2
        do_start();
        send(8'h00, 1'b0); send(8'h41, 1'b0); send(8'h82, 1'b0); send(8'hC3, 1'b0);
        do_flush();
        push_report();
        drain(2, 3, -1, hs);
        check_eq("t2_handshakes", hs, 6);
        check_idle("t2_end");

        // flush with no samples
        do_start();
        do_flush();
        push_report();
        drain(-1, 0, -1, hs);
        check_eq("t3_ovf", int'(ovf1), 0);

        // flush coincident with 3rd accept
        do_start();
        send(5, 1'b0); send(8'h80, 1'b0); send(8'hFF, 1'b1);
        push_report();
        drain(-1, 0, -1, hs);
        check_eq("t4_handshakes", hs, 6);

        // reset while idx 3 is on offer
        do_start();
        send(1, 1'b0); send(2, 1'b0);
        do_flush();
        push_report();
        drain(-1, 0, 3, hs);
        check_eq("t5_at_idx3", int'(rpt_idx1), 3);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_in_ready", int'(in_ready1), 0);
        check_eq("t5_rst_data", int'(rpt_data1), 0);
        check_eq("t5_rst_ovf", int'(ovf1), 0);
        check_idle("t5_rst");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        rpt_ready = 1'b1;
        @(negedge clk);
        check_idle("t5_after");
        do_start();
        send(8'h40, 1'b0); send(8'h43, 1'b0); send(8'hC0, 1'b0);
        do_flush();
        push_report();
        drain(-1, 0, -1, hs);
        check_eq("t5_clean_handshakes", hs, 6);

        // saturation on the 20-sample instance
        sel = 1'b1;
        do_start();
        for (int i = 0; i < 20; i++) begin
            send(1, 1'b0);
            if (i == 14) check_eq("t6_ovf_before", int'(ovf2), 0);
            if (i == 15) check_eq("t6_ovf_after", int'(ovf2), 1);
        end
        check_eq("t6_model_ovf", m_ovf, 1);
        push_report();
        drain(-1, 0, -1, hs);
        check_eq("t6_handshakes", hs, 6);
        check_eq("t6_ovf_sticky", int'(ovf2), 1);
        do_start();
        check_eq("t6_ovf_cleared", int'(ovf2), 0);
        do_flush();
        push_report();
        drain(-1, 0, -1, hs);
        check_idle("t6_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sample_stats.md
Name: sample_stats

Overview:
Synthesisable run-time statistics collector for testbench and in-design monitoring. It accepts a stream of samples over a valid/ready handshake and tallies three things per run: odd samples (pass), even samples (fail), and a histogram of samples by MSB range. At end of run, or on flush, it streams a report of all tallies over a second valid/ready handshake. It generalises the fixed 4-bit pass/fail tally with parametrised widths, bin count and run length, adds saturation with an overflow flag, and adds a flow-controlled report readout.

Parameters:
DATA_W, 8, sample width.
NUM_BINS, 4, histogram bins; power of two, 2..2**DATA_W; bin = in_data[DATA_W-1 -: $clog2(NUM_BINS)].
CNT_W, 4, width of every tally counter.
NUM_SAMPLES, 13, samples per run before automatic report; must be >= 1.

Ports:
clk  in  1  clock, all logic on posedge.
rst  in  1  asynchronous, active-high reset.
start  in  1  begin a run; sampled only in IDLE.
flush  in  1  end the run early; sampled only in COLLECT.
in_valid  in  1  sample valid.
in_ready  out  1  block can accept a sample.
in_data  in  DATA_W  sample value.
rpt_valid  out  1  report word valid.
rpt_ready  in  1  consumer accepts the report word.
rpt_data  out  CNT_W  report word value.
rpt_idx  out  $clog2(NUM_BINS+2)  report word index.
rpt_last  out  1  final report word.
busy  out  1  high in COLLECT or REPORT.
ovf  out  1  sticky: some tally saturated this run.

Behaviour:
- Reset: state=IDLE; all tallies, sample count and ovf=0; in_ready=0; rpt_valid=0; rpt_data=0; rpt_idx=0; rpt_last=0; busy=0.
- IDLE: in_ready=0. start=1 -> clear all tallies, sample count and ovf, then go to COLLECT on the next edge. Tallies from the previous run stay readable internally until start.
- COLLECT: in_ready=1; busy=1. Accept when in_valid && in_ready.
  - Per accepted sample: in_data[0]=1 -> pass+1, else fail+1; bin[in_data MSBs]+1; sample count+1.
  - Tallies update on the edge after acceptance (one-cycle latency).
- Saturation: a tally at 2**CNT_W-1 holds its value; an increment attempt sets ovf=1. ovf stays high until the next start or reset. The sample count itself never saturates (width $clog2(NUM_SAMPLES+1)).
- COLLECT -> REPORT:
  - on the edge that accepts the NUM_SAMPLES-th sample, or
  - on any edge with flush=1.
  - flush and an accepted sample in the same cycle: the sample is counted, then go to REPORT.
  - in_ready drops to 0 in the first REPORT cycle.
- REPORT: busy=1; rpt_valid=1 from the first REPORT cycle.
  - Word order by rpt_idx: 0=pass, 1=fail, 2..NUM_BINS+1 = bin0..bin(NUM_BINS-1).
  - rpt_data and rpt_idx are registered. They are stable while rpt_valid && !rpt_ready and advance by one on each handshake.
  - rpt_last=1 only with idx NUM_BINS+1.
  - Handshake on the last word -> IDLE next edge; rpt_valid=0, rpt_idx=0, rpt_last=0.
- flush with zero samples: report is all zeros; ovf=0.
- start outside IDLE and flush outside COLLECT are ignored.
- rst asserted mid-run or mid-report: immediate return to reset values; no partial report completes.

Decomposition:
- Package sample_stats_pkg:
  - state enum {IDLE, COLLECT, REPORT};
  - localparams RPT_PASS=0, RPT_FAIL=1, RPT_BIN0=2;
  - function for bin-index width.
- Sub-module sat_counter (params W), one instance per tally:
  - ports: clk, rst, clr, inc, value, sat_hit;
  - sat_hit pulses when inc arrives at max.
- The top level holds the FSM, the sample counter, the report mux and the ovf OR-reduction.

Test Plan:
- Defaults; start; feed 0..12 back-to-back, valid every cycle -> REPORT after 13th accept; words (idx:data) 0:6, 1:7, 2:13, 3:0, 4:0, 5:0; rpt_last on idx 5; ovf=0; then IDLE.
- Defaults; feed 0x00,0x41,0x82,0xC3 then flush -> pass=2, fail=2, bins 1,1,1,1; six report words.
- NUM_SAMPLES=20; feed 0x01 x20 -> pass=15, fail=0, bin0=15; ovf=1 after 16th accept; next start clears ovf.
- Report backpressure: rpt_ready low 3 cycles on idx 2 -> rpt_valid high, idx/data stable; resumes on ready; exactly 6 handshakes total.
- flush with no samples, and flush coincident with the 3rd accept -> all-zero report for the first case; 3 counted for the second.
- start while in COLLECT ignored; rst asserted during REPORT idx 3 -> all outputs at reset values same cycle; next start gives a clean run.
